// File: rtl/ula_arbiter.sv
// Round-robin arbiter that shares one external 4-bit logic ULA among N_REQ requesters.
// The winner's operands are latched, the ULA result is captured, and a done pulse returns it.
module ula_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*W-1:0]     req_op_a,
    input  logic [N_REQ*W-1:0]     req_op_b,
    input  logic [N_REQ*SEL_W-1:0] req_sel,
    output logic [N_REQ-1:0]       gnt,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [W-1:0]           result,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count,
    output logic [W-1:0]           ula_op_a,
    output logic [W-1:0]           ula_op_b,
    output logic [SEL_W-1:0]       ula_sel,
    input  logic [W-1:0]           ula_out
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [W-1:0]     result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    pick_off;
    logic [ID_W:0]      pick_sum;
    logic [ID_W-1:0]    pick_id;

    // Rotate so the rr pointer sits at bit 0; the lowest set bit is the winner's offset.
    always_comb begin
        req_dbl  = {req, req} >> rr_q;
        req_rot  = req_dbl[N_REQ-1:0];
        pick_off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_off = ID_W'(j);
            end
        end
        pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
        if (pick_sum >= (ID_W+1)'(N_REQ)) begin
            pick_sum = pick_sum - (ID_W+1)'(N_REQ);
        end
        pick_id = pick_sum[ID_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rr_d      = rr_q;
        done_id_d = done_id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sel_d     = sel_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    id_d = pick_id;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_id == ID_W'(i)) begin
                            op_a_d = req_op_a[i*W +: W];
                            op_b_d = req_op_b[i*W +: W];
                            sel_d  = req_sel[i*SEL_W +: SEL_W];
                        end
                    end
                    state_d = StExec;
                end
            end
            StExec: begin
                result_d  = ula_out;
                done_id_d = id_q;
                state_d   = StDone;
            end
            StDone: begin
                rr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            id_q      <= '0;
            rr_q      <= '0;
            done_id_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sel_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            done_id_q <= done_id_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sel_q     <= sel_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = (state_q != StIdle) && (id_q == ID_W'(i));
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign done_id  = done_id_q;
    assign result   = result_q;
    assign op_count = cnt_q;
    assign ula_op_a = op_a_q;
    assign ula_op_b = op_b_q;
    assign ula_sel  = sel_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: a transaction-level model checked every cycle, plus literal
// expectations for the ULA table, latency, round-robin order and counter saturation.
module tb_ula_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 3;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  req_op_a, req_op_b;
    logic [N*SW-1:0] req_sel;

    logic [N-1:0]  gnt, gnt2;
    logic          done, done2, busy, busy2;
    logic [IW-1:0] done_id, done_id2;
    logic [W-1:0]  result, result2;
    logic [7:0]    op_count;
    logic [1:0]    op_count2;
    logic [W-1:0]  ula_op_a, ula_op_b, ula_out, ula_op_a2, ula_op_b2, ula_out2;
    logic [SW-1:0] ula_sel, ula_sel2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ula_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [SW-1:0] s);
        case (s)
            3'd0:    return a;
            3'd1:    return ~a;
            3'd2:    return b;
            3'd3:    return ~b;
            3'd4:    return a & b;
            3'd5:    return ~a & b;
            3'd6:    return a & ~b;
            default: return ~(a | b);
        endcase
    endfunction

    assign ula_out  = ula_f(ula_op_a, ula_op_b, ula_sel);
    assign ula_out2 = ula_f(ula_op_a2, ula_op_b2, ula_sel2);

    ula_arbiter #(.N_REQ(N), .W(W), .SEL_W(SW), .ID_W(IW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op_a(req_op_a), .req_op_b(req_op_b),
        .req_sel(req_sel), .gnt(gnt), .done(done), .done_id(done_id), .result(result),
        .busy(busy), .op_count(op_count), .ula_op_a(ula_op_a), .ula_op_b(ula_op_b),
        .ula_sel(ula_sel), .ula_out(ula_out)
    );

    ula_arbiter #(.N_REQ(N), .W(W), .SEL_W(SW), .ID_W(IW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .req_op_a(req_op_a), .req_op_b(req_op_b),
        .req_sel(req_sel), .gnt(gnt2), .done(done2), .done_id(done_id2), .result(result2),
        .busy(busy2), .op_count(op_count2), .ula_op_a(ula_op_a2), .ula_op_b(ula_op_b2),
        .ula_sel(ula_sel2), .ula_out(ula_out2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 waits, phase 1 is the op in flight, phase 2 returns it.
    function automatic int pick(input logic [N-1:0] r, input int rr);
        for (int k = 0; k < N; k++) begin
            if (r[(rr + k) % N]) return (rr + k) % N;
        end
        return 0;
    endfunction

    int m_phase, m_rr, m_win, m_did, m_cnt, m_cnt2;
    logic [W-1:0]  m_a, m_b, m_res;
    logic [SW-1:0] m_sel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_rr <= 0; m_win <= 0; m_did <= 0; m_cnt <= 0; m_cnt2 <= 0;
            m_a <= '0; m_b <= '0; m_sel <= '0; m_res <= '0;
        end else if (m_phase == 0) begin
            if (req != '0) begin
                m_win   <= pick(req, m_rr);
                m_a     <= req_op_a[pick(req, m_rr)*W +: W];
                m_b     <= req_op_b[pick(req, m_rr)*W +: W];
                m_sel   <= req_sel[pick(req, m_rr)*SW +: SW];
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            m_res   <= ula_f(m_a, m_b, m_sel);
            m_did   <= m_win;
            m_phase <= 2;
        end else begin
            m_rr    <= (m_win + 1) % N;
            m_cnt   <= (m_cnt == 255) ? 255 : m_cnt + 1;
            m_cnt2  <= (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("gnt", 32'(gnt), (m_phase != 0) ? (32'd1 << m_win) : 32'd0);
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("done", 32'(done), 32'(m_phase == 2));
            check("done_id", 32'(done_id), 32'(m_did));
            check("result", 32'(result), 32'(m_res));
            check("op_count", 32'(op_count), 32'(m_cnt));
            check("op_count_sat", 32'(op_count2), 32'(m_cnt2));
            check("ula_op_a", 32'(ula_op_a), 32'(m_a));
            check("ula_op_b", 32'(ula_op_b), 32'(m_b));
            check("ula_sel", 32'(ula_sel), 32'(m_sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SW-1:0] s);
        req_op_a[id*W +: W]  = a;
        req_op_b[id*W +: W]  = b;
        req_sel[id*SW +: SW] = s;
    endtask

    task automatic wait_any_done(output int id, output bit ok);
        ok = 1'b0;
        id = -1;
        for (int n = 0; n < 12 && !ok; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                id = int'(done_id);
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done within 12 cycles at %0t", $time);
        end
    endtask

    task automatic apply_reset();
        req = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [W-1:0] sel_tab [8] = '{4'b1100, 4'b0011, 4'b1010, 4'b0101,
                                  4'b1000, 4'b0010, 4'b0100, 4'b0001};
    int rr_order [5] = '{0, 1, 2, 3, 0};
    int sat_tab [5] = '{1, 2, 3, 3, 3};

    initial begin
        int  id;
        int  prev_cyc;
        bit  ok;

        req = '0; req_op_a = '0; req_op_b = '0; req_sel = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset during EXEC aborts the op.
        set_op(0, 4'b0110, 4'b0000, 3'b001);
        req[0] = 1'b1;
        @(posedge clk);
        #2;
        check("abort_in_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_gnt", 32'(gnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ula_a", 32'(ula_op_a), 32'd0);
        check("abort_ula_sel", 32'(ula_sel), 32'd0);
        check("abort_op_count", 32'(op_count), 32'd0);
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) tick();
        check("abort_no_count", 32'(op_count), 32'd0);
        req[0] = 1'b1;
        wait_any_done(id, ok);
        if (ok) check("fresh_result", 32'(result), 32'b1001);
        tick();
        req = '0;
        check("fresh_count", 32'(op_count), 32'd1);

        // Single op with cycle-exact grant and done.
        apply_reset();
        set_op(0, 4'b1100, 4'b1010, 3'b100);
        req[0] = 1'b1;
        @(negedge clk);
        check("single_gnt_idle", 32'(gnt), 32'd0);
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'b0001);
        check("single_ula_sel", 32'(ula_sel), 32'b100);
        @(negedge clk);
        check("single_done", 32'(done), 32'd1);
        check("single_result", 32'(result), 32'b1000);
        check("single_done_id", 32'(done_id), 32'd0);
        tick();
        req = '0;
        check("single_count", 32'(op_count), 32'd1);

        // All eight selectors back to back from requester 2.
        req[2] = 1'b1;
        prev_cyc = 0;
        for (int s = 0; s < 8; s++) begin
            set_op(2, 4'b1100, 4'b1010, 3'(s));
            wait_any_done(id, ok);
            if (ok) begin
                check("sel_id", 32'(id), 32'd2);
                check("sel_result", 32'(result), 32'(sel_tab[s]));
                if (s > 0) check("sel_spacing", 32'(cyc - prev_cyc), 32'd3);
                prev_cyc = cyc;
            end
            tick();
        end
        req = '0;
        repeat (2) tick();

        // Round-robin with all four requesting.
        apply_reset();
        for (int i = 0; i < N; i++) set_op(i, 4'(i * 3 + 1), 4'(9 - i), 3'(i + 2));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_any_done(id, ok);
            if (ok) begin
                check("rr_order", 32'(id), 32'(rr_order[k]));
                tick();
                req[id] = 1'b0;
                tick();
                req[id] = 1'b1;
            end
        end
        req = '0;
        repeat (4) tick();

        // Operand change after latching has no effect.
        apply_reset();
        set_op(1, 4'b0011, 4'b0101, 3'b111);
        req[1] = 1'b1;
        @(posedge clk);
        #1;
        req_op_a[1*W +: W] = 4'b1111;
        wait_any_done(id, ok);
        if (ok) begin
            check("iso_id", 32'(id), 32'd1);
            check("iso_result", 32'(result), 32'b1000);
        end
        tick();
        req = '0;

        // Saturating counter on the CNT_W=2 instance.
        apply_reset();
        set_op(3, 4'b0101, 4'b0011, 3'b110);
        req[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_any_done(id, ok);
            tick();
            check("sat_count", 32'(op_count2), 32'(sat_tab[k]));
        end
        req = '0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares one 4-bit logic ULA (combinational, 3-bit selector, eight logic ops) among N_REQ requesters.
- Arbitrates pending requests round-robin and latches the winner's operands and selector.
- Drives the ULA from registers, captures its result, and returns it to the winner with a one-cycle done pulse.
- Sits between requesting control units and the single ULA instance. The ULA stays outside this block.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 4, operand/result width; must match the ULA
SEL_W, 3, ULA selector width
ID_W, 2, requester index width; must satisfy 2**ID_W >= N_REQ
CNT_W, 8, completed-operation counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
req  in  N_REQ  per-requester request level
req_op_a  in  N_REQ*W  operand A, slice i = requester i
req_op_b  in  N_REQ*W  operand B, slice i = requester i
req_sel  in  N_REQ*SEL_W  ULA selector, slice i = requester i
gnt  out  N_REQ  one-hot grant, high while the requester's op is in flight
done  out  1  one-cycle result-valid pulse
done_id  out  ID_W  index of the requester owning done/result
result  out  W  captured ULA output
busy  out  1  high in any state other than IDLE
op_count  out  CNT_W  completed operations, saturating
ula_op_a  out  W  to ULA op_a
ula_op_b  out  W  to ULA op_b
ula_sel  out  SEL_W  to ULA sel_ULA
ula_out  in  W  from ULA out

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, done=0, done_id=0, result=0, busy=0, op_count=0, rr pointer=0, ula_op_a/ula_op_b/ula_sel=0.
- A reset during EXEC or DONE aborts the operation. No done is issued and the op is not counted.
- FSM states: IDLE -> EXEC -> DONE -> IDLE. Each state lasts exactly one cycle except IDLE, which waits.
- IDLE: if req != 0, choose the winner as the first set req bit starting at the rr pointer, wrapping from N_REQ-1 to 0. Then:
  - Latch winner id, req_op_a, req_op_b and req_sel slices into internal registers.
  - Set gnt[winner] and go to EXEC.
  - If req == 0, stay in IDLE; all outputs hold except done=0.
- ula_op_a, ula_op_b and ula_sel are driven only from the latched registers, never combinationally from req_* inputs. They are stable from EXEC through DONE.
- EXEC: register ula_out into result. Go to DONE.
- DONE:
  - done=1, done_id=winner, gnt[winner] still 1.
  - On exit: gnt->0, rr pointer->(winner+1) mod N_REQ, op_count increments (holds at all-ones).
  - Go to IDLE.
- result and done_id hold their values after DONE until the next capture.
- Latency: request sampled in IDLE at edge T gives done high during cycle T+2 (relative to the latching edge). Peak throughput is one op per 3 cycles.
- Requester rules:
  - Hold req and operands stable until done with its id is seen.
  - Deassert req on the edge ending DONE.
  - A req still high when IDLE samples it is a new request.
  - Operand changes after the latching edge have no effect on the in-flight op.
- Requests arriving while busy are not lost; they are evaluated at the next IDLE cycle.
- Simultaneous requests: exactly one is granted per IDLE sample. The rr pointer guarantees each pending requester is served within N_REQ operations.
- req bits at indices >= N_REQ do not exist. done_id never exceeds N_REQ-1.

Test Plan:
- Reset mid-EXEC: req0 with a=4'b0110, sel=3'b001; assert rst in EXEC -> all outputs 0 immediately, no done, op_count=0. After release, a fresh req0 completes normally.
- Single op: req0, a=4'b1100, b=4'b1010, sel=3'b100 -> gnt=0001 one cycle after sampling, ula_sel=100, done during DONE with result=4'b1000, done_id=0, op_count=1.
- All selectors: requester 2, a=4'b1100, b=4'b1010, sel 000..111 sequentially -> results 1100, 0011, 1010, 0101, 1000, 0010, 0100, 0001, each exactly 3 cycles apart.
- Round-robin fairness: req=4'b1111 held continuously, each requester dropping req on its own done and reasserting next cycle -> done_id order 0,1,2,3,0. No requester starves and gnt is always one-hot or zero.
- Operand isolation: req1 latched with a=4'b0011, b=4'b0101, sel=3'b111; change req_op_a to 4'b1111 during EXEC -> result=4'b1000 (from the latched value).
- Counter saturation: with CNT_W=2, complete 5 ops -> op_count reads 1,2,3,3,3.
